mc_cpu: RTL
===========

MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter DW, default 8, data/instruction word width; legal DW >= 8.
REQ-002 Parameter AW, localparam DW-3, address and PC width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-007 mem_addr  output  AW  transaction address.
REQ-008 mem_wdata  output  DW  write data; equals accumulator.
REQ-009 mem_rdata  input  DW  read data, sampled on completing cycle.
REQ-010 mem_ready  input  1  completes the transaction in any cycle with mem_req=1.
REQ-011 acc_out  output  DW  accumulator A.
REQ-012 flags  output  3  {C,Z,N}.
REQ-013 halted  output  1  core stopped.

Function
REQ-014 Instruction: opcode = IR[DW-1:DW-3], operand = IR[AW-1:0].
REQ-015 Opcodes: 000 LDA (A<=M[op]), 001 STA (M[op]<=A), 010 ADD (A<=A+M[op]), 011 SUB (A<=A-M[op]), 100 AND (A<=A&M[op]), 101 JMP (PC<=op), 110 JZ (PC<=op if Z), 111 SYS.
REQ-016 SYS: operand 1 = HALT (see Configuration); any other operand = NOP.
REQ-017 States: FETCH, DECODE, MEM, EXEC, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready, IR<=mem_rdata, PC<=PC+1 (mod 2^AW), go to DECODE; otherwise hold.
REQ-019 DECODE (1 cycle): LDA/ADD/SUB/AND/STA go to MEM; JMP, JZ, SYS go to FETCH, with PC updated at the end of DECODE.
REQ-020 MEM: mem_req=1, mem_addr=operand, mem_we=1 only for STA; on mem_ready, STA goes to FETCH and the others latch MDR<=mem_rdata and go to EXEC.
REQ-021 EXEC (1 cycle): A and flags updated from MDR; go to FETCH.
REQ-022 mem_req=0 in DECODE, EXEC, HALT and during rst.
REQ-023 Zero-wait latency in cycles: JMP/JZ/SYS 2; STA 3; LDA/ADD/SUB/AND 4; each wait cycle adds 1.
REQ-024 Arithmetic is DW-bit modulo.
REQ-025 C on ADD is the carry-out; C on SUB is 1 when A < M unsigned (borrow).
REQ-026 Z = (result == 0) and N = result[DW-1]; both are updated on LDA/ADD/SUB/AND.
REQ-027 C changes only on ADD/SUB; STA, JMP, JZ and SYS leave all flags unchanged.
REQ-028 PC wrap: fetch at address 2^AW-1 sets PC to 0.
REQ-029 mem_ready while mem_req=0 is ignored.

Reset
REQ-030 While rst=1 at a clock edge: state<=FETCH; PC, A, IR, MDR, flags <= 0; halted<=0.
REQ-031 rst asserted mid-transaction abandons it: mem_req=0 the cycle after the reset edge; no register or memory update from the abandoned cycle.
REQ-032 After rst deasserts, the first fetch is from address 0.

Configuration
REQ-033 Macro MC_CPU_HALT_EN defined: SYS with operand 1 enters HALT; halted=1 and all registers frozen until rst.
REQ-034 Macro MC_CPU_HALT_EN undefined: SYS with operand 1 is a NOP; HALT state is absent; halted is tied to 0.

Verification (DW=8, zero-wait unless stated)
REQ-035 Program 0x0A,0x4B,0x2C with M[10]=0x05, M[11]=0xFB -> write of 0x00 to address 12; A=0x00, C=1, Z=1, N=0; STA write at cycle 11 after reset release.
REQ-036 Same program with mem_ready delayed 2 cycles per transaction -> identical results; each transaction +2 cycles; mem_addr/mem_we stable while waiting.
REQ-037 Taken JZ: A=0, Z=1, 0xC5 at address 0 -> next fetch at address 5. Not taken: Z=0 -> next fetch at address 1.
REQ-038 SUB 0x03-0x05 -> A=0xFE, C=1, N=1, Z=0.
REQ-039 0xE1: with MC_CPU_HALT_EN, halted=1 two cycles after fetch start and no further mem_req; without the macro, fetch continues at address 1.
REQ-040 rst pulsed during a MEM-state STA with mem_ready=0 -> no write occurs; mem_req=0 next cycle; refetch from address 0.

Source files
------------

// File: rtl/mc_cpu.sv
// mc_cpu: multicycle accumulator CPU with a single shared memory port.
// Each instruction runs FETCH -> DECODE -> (MEM -> (EXEC)) -> FETCH.
// Optional feature: define MC_CPU_HALT_EN to make SYS #1 stop the core until reset.
// The memory-port outputs are registered: they come from the next-state
// values. As a result, the port is idle for one cycle after every reset edge.
module mc_cpu #(
  parameter int unsigned DW = 8,
  localparam int unsigned AW = DW - 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] acc_out,
  output logic [2:0]    flags,
  output logic          halted
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3
`ifdef MC_CPU_HALT_EN
    , ST_HALT = 3'd4
`endif
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_JMP = 3'b101,
    OP_JZ  = 3'b110,
    OP_SYS = 3'b111
  } op_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic          req_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW:0]   sum;
  logic          xfer;
  op_t           opc, opc_d;
  logic [AW-1:0] operand;

  assign xfer      = mem_req & mem_ready;
  assign opc       = op_t'(ir_q[DW-1:DW-3]);
  assign opc_d     = op_t'(ir_d[DW-1:DW-3]);
  assign operand   = ir_q[AW-1:0];
  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign flags     = {c_q, z_q, n_q};

  // Next-state, datapath updates and next memory-port values
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    sum     = '0;

    case (state_q)
      ST_FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (opc)
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: state_d = ST_MEM;
          OP_JMP: begin
            pc_d    = operand;
            state_d = ST_FETCH;
          end
          OP_JZ: begin
            if (z_q) pc_d = operand;
            state_d = ST_FETCH;
          end
          OP_SYS: begin
`ifdef MC_CPU_HALT_EN
            state_d = (operand == AW'(1)) ? ST_HALT : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        if (xfer) begin
          if (opc == OP_STA) begin
            state_d = ST_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        case (opc)
          OP_LDA: acc_d = mdr_q;
          OP_ADD: begin
            sum   = {1'b0, acc_q} + {1'b0, mdr_q};
            acc_d = sum[DW-1:0];
            c_d   = sum[DW];
          end
          OP_SUB: begin
            acc_d = acc_q - mdr_q;
            c_d   = (acc_q < mdr_q);
          end
          OP_AND: acc_d = acc_q & mdr_q;
          default: acc_d = acc_q;
        endcase
        z_d     = (acc_d == '0);
        n_d     = acc_d[DW-1];
        state_d = ST_FETCH;
      end

`ifdef MC_CPU_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif

      default: state_d = ST_FETCH;
    endcase

    req_d  = (state_d == ST_FETCH) || (state_d == ST_MEM);
    we_d   = (state_d == ST_MEM) && (opc_d == OP_STA);
    addr_d = (state_d == ST_MEM) ? ir_d[AW-1:0] : pc_d;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Architectural registers and registered memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      mem_req  <= req_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
    end
  end

`ifdef MC_CPU_HALT_EN
  // Halt indicator, set on entry to HALT and held until reset
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_d == ST_HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule
